// File: rtl/keyboard_note_decoder.sv
// PS/2 scan-byte decoder for a one-octave-and-a-bit piano keyboard: tracks
// make/break/extended prefixes, the held note key and an adjustable octave.
module keyboard_note_decoder #(
   parameter logic [2:0]  DEFAULT_OCTAVE = 3'd4,
   parameter logic [25:0] TIMEOUT_CYCLES = 26'd50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scan_valid,
   input  logic [7:0] scan_code,
   output logic       note_in,
   output logic [3:0] note,
   output logic [2:0] octave,
   output logic       key_held,
   output logic [2:0] cur_octave,
   output logic [1:0] dbg_state_o
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_BREAK     = 2'd1;
   localparam logic [1:0] ST_EXT       = 2'd2;
   localparam logic [1:0] ST_EXT_BREAK = 2'd3;

   localparam logic [7:0] CODE_BREAK = 8'hF0;
   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_Z     = 8'h1A;
   localparam logic [7:0] CODE_X     = 8'h22;
   localparam logic [7:0] CODE_HIGHC = 8'h42;

   logic [1:0]  state_q, state_d;
   logic [25:0] cnt_q, cnt_d;
   logic        note_in_q, note_in_d;
   logic [3:0]  note_q, note_d;
   logic [2:0]  octave_q, octave_d;
   logic        key_held_q, key_held_d;
   logic [7:0]  held_q, held_d;
   logic [2:0]  cur_oct_q, cur_oct_d;

   logic        is_note;
   logic [3:0]  note_idx;
   logic        is_repeat;

   always_comb begin
      is_note  = 1'b1;
      note_idx = 4'd0;
      case (scan_code)
         8'h1C:   note_idx = 4'd0;
         8'h1D:   note_idx = 4'd1;
         8'h1B:   note_idx = 4'd2;
         8'h24:   note_idx = 4'd3;
         8'h23:   note_idx = 4'd4;
         8'h2B:   note_idx = 4'd5;
         8'h2C:   note_idx = 4'd6;
         8'h34:   note_idx = 4'd7;
         8'h35:   note_idx = 4'd8;
         8'h33:   note_idx = 4'd9;
         8'h3C:   note_idx = 4'd10;
         8'h3B:   note_idx = 4'd11;
         8'h42:   note_idx = 4'd0;
         default: is_note  = 1'b0;
      endcase
   end

   assign is_repeat = key_held_q && (scan_code == held_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      note_in_d  = 1'b0;
      note_d     = note_q;
      octave_d   = octave_q;
      key_held_d = key_held_q;
      held_d     = held_q;
      cur_oct_d  = cur_oct_q;

      if (scan_valid) begin
         cnt_d = 26'd0;
         case (state_q)
            ST_IDLE: begin
               if (scan_code == CODE_BREAK) begin
                  state_d = ST_BREAK;
               end else if (scan_code == CODE_EXT) begin
                  state_d = ST_EXT;
               end else if (scan_code == CODE_Z) begin
                  if (cur_oct_q != 3'd0) cur_oct_d = cur_oct_q - 3'd1;
               end else if (scan_code == CODE_X) begin
                  if (cur_oct_q != 3'd7) cur_oct_d = cur_oct_q + 3'd1;
               // A make arriving while a pulse is still high is dropped so
               // note_in can never stay high for two cycles in a row.
               end else if (is_note && !is_repeat && !note_in_q) begin
                  note_in_d  = 1'b1;
                  note_d     = note_idx;
                  key_held_d = 1'b1;
                  held_d     = scan_code;
                  if (scan_code == CODE_HIGHC && cur_oct_q != 3'd7)
                     octave_d = cur_oct_q + 3'd1;
                  else
                     octave_d = cur_oct_q;
               end
            end
            ST_BREAK: begin
               state_d = ST_IDLE;
               if (is_repeat) key_held_d = 1'b0;
            end
            ST_EXT: begin
               state_d = (scan_code == CODE_BREAK) ? ST_EXT_BREAK : ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         if ((cnt_q + 26'd1) >= TIMEOUT_CYCLES) begin
            state_d = ST_IDLE;
            cnt_d   = 26'd0;
         end else begin
            cnt_d = cnt_q + 26'd1;
         end
      end else begin
         cnt_d = 26'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 26'd0;
         note_in_q  <= 1'b0;
         note_q     <= 4'd0;
         octave_q   <= DEFAULT_OCTAVE;
         key_held_q <= 1'b0;
         held_q     <= 8'h00;
         cur_oct_q  <= DEFAULT_OCTAVE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         note_in_q  <= note_in_d;
         note_q     <= note_d;
         octave_q   <= octave_d;
         key_held_q <= key_held_d;
         held_q     <= held_d;
         cur_oct_q  <= cur_oct_d;
      end
   end

   assign note_in     = note_in_q;
   assign note        = note_q;
   assign octave      = octave_q;
   assign key_held    = key_held_q;
   assign cur_octave  = cur_oct_q;
   assign dbg_state_o = state_q;

endmodule
